rggen_host_access_initiator: RTL
================================

RGGEN_HOST_ACCESS_INITIATOR -- requirements
Module: rggen_host_access_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, register byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter TOTAL_REGISTERS, default 1, number of per-register select lines.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait-state cycles; legal range 1..65535.
REQ-005 SHALL have ports, in order:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- i_command_valid  input  1  host command valid.
- o_command_ready  output  1  command accepted.
- i_command_write  input  1  1 = write, 0 = read.
- i_command_address  input  ADDRESS_WIDTH  target address.
- i_command_write_data  input  DATA_WIDTH  write data.
- o_response_valid  output  1  response valid.
- i_response_ready  input  1  host takes response.
- o_response_status  output  2  access status.
- o_response_read_data  output  DATA_WIDTH  read data.
- o_read  output  1  read strobe to register decoders.
- o_write  output  1  write strobe to register decoders.
- o_address  output  ADDRESS_WIDTH  address to register decoders.
- o_write_data  output  DATA_WIDTH  write data to registers.
- i_select  input  TOTAL_REGISTERS  per-register decoder select.
- i_wait  input  1  any selected register requests a wait-state.
- i_read_data  input  TOTAL_REGISTERS*DATA_WIDTH  flattened per-register read data, register 0 in LSBs.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, RESPONSE.
REQ-007 IDLE: o_command_ready = 1; on i_command_valid SHALL latch write, address, write data and enter ACCESS next cycle.
REQ-008 o_command_ready SHALL be 0 in ACCESS and RESPONSE; one outstanding command only.
REQ-009 ACCESS: o_read = ~write, o_write = write, o_address/o_write_data = latched values, held stable.
REQ-010 ACCESS, no bit of i_select set: SHALL enter RESPONSE with status DECODE_ERROR (2'b11), read data 0, regardless of i_wait.
REQ-011 ACCESS, any select set and i_wait = 0: SHALL enter RESPONSE with status OKAY (2'b00); read data = bitwise OR of i_read_data slices whose select is set (read) or 0 (write).
REQ-012 ACCESS, any select set and i_wait = 1: SHALL remain in ACCESS with strobes held.
REQ-013 Minimum latency: command accepted cycle N, o_response_valid asserted cycle N+2.
REQ-014 RESPONSE: o_response_valid = 1 with status/data stable until i_response_ready = 1, then IDLE next cycle; o_read/o_write = 0.
REQ-015 A new command SHALL not be accepted in the cycle the response handshake completes.
REQ-016 o_address/o_write_data SHALL hold the last latched value outside ACCESS.

Reset
REQ-017 rst asserted SHALL immediately force IDLE, o_command_ready = 1 (after reset release), o_response_valid = 0, o_read = 0, o_write = 0, o_address = 0, o_write_data = 0, o_response_status = 0, o_response_read_data = 0, timeout counter 0.
REQ-018 Reset mid-ACCESS or mid-RESPONSE SHALL drop the transaction with no response.

Configuration
REQ-019 Macro RGGEN_HOST_ACCESS_TIMEOUT_EN defined: cycles counted in ACCESS while i_wait = 1; when count reaches TIMEOUT_CYCLES, SHALL enter RESPONSE with status SLAVE_ERROR (2'b10), read data 0; counter cleared on entering ACCESS.
REQ-020 Macro undefined: no counter logic; ACCESS waits indefinitely on i_wait; TIMEOUT_CYCLES unused.

Structure
REQ-021 Status encodings (OKAY, EXOKAY 2'b01 reserved, SLAVE_ERROR, DECODE_ERROR) SHALL be a typedef enum in shared package rggen_rtl_pkg.
REQ-022 Read-data OR-mux SHALL be sub-module rggen_read_data_mux (params TOTAL_REGISTERS, DATA_WIDTH).

Verification
REQ-023 Read 0x0004, i_select = 2'b10, slice1 = 0xDEADBEEF, i_wait = 0 -> o_read one cycle, response OKAY/0xDEADBEEF at N+2.
REQ-024 Write 0x0000 data 0x12345678, i_select = 2'b01 -> o_write one cycle, o_write_data 0x12345678, status OKAY, read data 0.
REQ-025 Read 0x00F0, i_select = 0 -> DECODE_ERROR, read data 0, at N+2.
REQ-026 Select set, i_wait high 3 cycles, i_response_ready low 2 cycles -> strobes held 4 cycles, response held stable until ready.
REQ-027 With RGGEN_HOST_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, i_wait stuck high -> SLAVE_ERROR after 4 wait cycles; without macro -> no response.
REQ-028 rst pulsed during ACCESS -> strobes low immediately, o_response_valid stays 0, next command completes normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen host access path: response status codes and
// the host access initiator state encoding.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status_e;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'b00,
    STATE_ACCESS   = 2'b01,
    STATE_RESPONSE = 2'b10
  } rggen_host_state_e;

endpackage

// File: rtl/rggen_read_data_mux.sv
// Read-data OR-mux: combines the read data of every selected register.
// Registers that are not selected contribute zero.
module rggen_read_data_mux #(
  parameter int TOTAL_REGISTERS = 1,
  parameter int DATA_WIDTH      = 32
) (
  input  logic [TOTAL_REGISTERS-1:0]            select,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0]                 data
);

  // OR together the slices whose select bit is set
  always_comb begin
    data = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      if (select[i]) begin
        data = data | read_data[i*DATA_WIDTH+:DATA_WIDTH];
      end else begin
        data = data;
      end
    end
  end

endmodule

// File: rtl/rggen_host_access_initiator.sv
// Single-outstanding host command to register-strobe bridge (IDLE/ACCESS/RESPONSE).
// Optional wait-state timeout enabled by macro RGGEN_HOST_ACCESS_TIMEOUT_EN.
module rggen_host_access_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_command_valid,
  output logic                                  o_command_ready,
  input  logic                                  i_command_write,
  input  logic [ADDRESS_WIDTH-1:0]              i_command_address,
  input  logic [DATA_WIDTH-1:0]                 i_command_write_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data,
  output logic                                  o_read,
  output logic                                  o_write,
  output logic [ADDRESS_WIDTH-1:0]              o_address,
  output logic [DATA_WIDTH-1:0]                 o_write_data,
  input  logic [TOTAL_REGISTERS-1:0]            i_select,
  input  logic                                  i_wait,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_read_data
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_illegal_timeout_cycles
  end

  rggen_host_state_e       state;
  rggen_status_e           response_status;
  logic                    command_write;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic                    access_done;
  rggen_status_e           access_status;
  logic [DATA_WIDTH-1:0]   access_data;

  rggen_read_data_mux #(
    .TOTAL_REGISTERS (TOTAL_REGISTERS),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_read_data_mux (
    .select    (i_select),
    .read_data (i_read_data),
    .data      (mux_data)
  );

`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
  logic [15:0] wait_count;
  logic        timeout_hit;

  // The current wait cycle is the one that reaches the limit
  assign timeout_hit = ({1'b0, wait_count} + 17'd1) >= 17'(TIMEOUT_CYCLES);
`endif

  // Resolve how the current ACCESS cycle ends: decode error wins over wait
  always_comb begin
    access_done   = 1'b0;
    access_status = RGGEN_OKAY;
    access_data   = {DATA_WIDTH{1'b0}};
    if (!(|i_select)) begin
      access_done   = 1'b1;
      access_status = RGGEN_DECODE_ERROR;
    end else if (!i_wait) begin
      access_done   = 1'b1;
      access_status = RGGEN_OKAY;
      access_data   = command_write ? {DATA_WIDTH{1'b0}} : mux_data;
    end else begin
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
      if (timeout_hit) begin
        access_done   = 1'b1;
        access_status = RGGEN_SLAVE_ERROR;
      end else begin
        access_done = 1'b0;
      end
`else
      access_done = 1'b0;
`endif
    end
  end

  // Main FSM with all host and decoder-side outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= STATE_IDLE;
      o_command_ready      <= 1'b1;
      o_response_valid     <= 1'b0;
      response_status      <= RGGEN_OKAY;
      o_response_read_data <= {DATA_WIDTH{1'b0}};
      o_read               <= 1'b0;
      o_write              <= 1'b0;
      o_address            <= {ADDRESS_WIDTH{1'b0}};
      o_write_data         <= {DATA_WIDTH{1'b0}};
      command_write        <= 1'b0;
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
      wait_count           <= 16'd0;
`endif
    end else begin
      case (state)
        STATE_IDLE: begin
          if (i_command_valid) begin
            state           <= STATE_ACCESS;
            o_command_ready <= 1'b0;
            command_write   <= i_command_write;
            o_address       <= i_command_address;
            o_write_data    <= i_command_write_data;
            o_read          <= ~i_command_write;
            o_write         <= i_command_write;
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
            wait_count      <= 16'd0;
`endif
          end
        end
        STATE_ACCESS: begin
          if (access_done) begin
            state                <= STATE_RESPONSE;
            o_read               <= 1'b0;
            o_write              <= 1'b0;
            o_response_valid     <= 1'b1;
            response_status      <= access_status;
            o_response_read_data <= access_data;
          end
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
          else begin
            wait_count <= wait_count + 16'd1;
          end
`endif
        end
        STATE_RESPONSE: begin
          // Ready only returns the cycle after the handshake
          if (i_response_ready) begin
            state            <= STATE_IDLE;
            o_response_valid <= 1'b0;
            o_command_ready  <= 1'b1;
          end
        end
        default: begin
          state            <= STATE_IDLE;
          o_command_ready  <= 1'b1;
          o_response_valid <= 1'b0;
          o_read           <= 1'b0;
          o_write          <= 1'b0;
        end
      endcase
    end
  end

  assign o_response_status = response_status;

endmodule
